vga_text_console_master: RTL and testbench
==========================================

// Module: vga_text_console_master
// PURPOSE
//  Avalon-MM master that writes into the VGA text-mode VRAM slave (2 chars per 32-bit word).
//  Takes a valid/ready character stream (code + colour attribute) and keeps an 80x30 cursor.
//  Issues one byte-enabled VRAM write per printable char; handles CR/LF/BS and full-screen clear.
//  Lets hardware (e.g. the pedal status logic) print text without a CPU.
// PARAMETERS
//  COLS       80   characters per row; must be even
//  ROWS       30   rows per screen
//  ADDR_W     12   Avalon word-address width
//  BASE_ADDR  0    word address of VRAM char (0,0)
// PORTS
//  CLK              in   1       system clock, 50 MHz; the only clock
//  RESET_N          in   1       asynchronous, active-low reset
//  CHAR_VALID       in   1       character present
//  CHAR_READY       out  1       block accepts character this cycle
//  CHAR_CODE        in   8       [7]=inverse, [6:0]=glyph code
//  CHAR_ATTR        in   8       [7:4]=fg palette idx, [3:0]=bg palette idx
//  CLEAR_REQ        in   1       one-cycle pulse: clear screen
//  CLEAR_ATTR       in   8       attribute used for clear fill
//  BUSY             out  1       write/clear in progress or clear pending
//  CURSOR_COL       out  7       current column, 0..COLS-1
//  CURSOR_ROW       out  5       current row, 0..ROWS-1
//  AVM_ADDR         out  ADDR_W  word address
//  AVM_WRITE        out  1       write request
//  AVM_BYTE_EN      out  4       byte enables
//  AVM_WRITEDATA    out  32      write data
//  AVM_WAITREQUEST  in   1       slave stall
// BEHAVIOUR
//  - Reset (async, RESET_N=0): state IDLE, cursor (0,0), clear_pend=0.
//    AVM_WRITE=0, AVM_ADDR=0, AVM_BYTE_EN=0, AVM_WRITEDATA=0. CHAR_READY=0 while in reset. BUSY=0.
//  - Reset mid-write/clear aborts at once: AVM_WRITE drops; no resume.
//  - FSM states IDLE, WRITE, CLEAR. All AVM_* outputs are registered.
//  - CHAR_READY = (state==IDLE) & ~clear_pend & ~CLEAR_REQ. Accept = CHAR_VALID & CHAR_READY.
//  - Control codes (CHAR_CODE==0x0A/0x0D/0x08) are handled in the accept cycle and issue no write:
//    - 0x0A LF: col=0, row+1.
//    - 0x0D CR: col=0.
//    - 0x08 BS: col-1 if col>0, else no change.
//  - Printable (any other code): go to WRITE next cycle.
//    - idx=row*COLS+col; AVM_ADDR=BASE_ADDR+idx[11:1].
//    - col even: BYTE_EN=0011, DATA={16'h0,CODE,ATTR}.
//    - col odd:  BYTE_EN=1100, DATA={CODE,ATTR,16'h0}.
//  - WRITE: AVM_WRITE=1; ADDR/DATA/BYTE_EN held stable while AVM_WAITREQUEST=1.
//    - First cycle with WAITREQUEST=0 completes the write; cursor advances; next state IDLE.
//  - Latency: accept in cycle N -> AVM_WRITE high in N+1. With no stall, CHAR_READY is high again in N+2.
//  - Cursor advance: col+1. At col==COLS-1: col=0, row+1. Row past ROWS-1 wraps to 0 (no scroll).
//  - CLEAR_REQ in IDLE -> CLEAR next cycle. It wins over CHAR_VALID in the same cycle (char not accepted).
//  - CLEAR_REQ during WRITE sets clear_pend. Clear starts on return to IDLE, before the next char.
//  - CLEAR_REQ during CLEAR is ignored.
//  - CLEAR: word counter 0..COLS*ROWS/2-1.
//    - Each write: ADDR=BASE_ADDR+cnt, BYTE_EN=1111, DATA={8'h20,CLEAR_ATTR,8'h20,CLEAR_ATTR}.
//    - CLEAR_ATTR is latched at request.
//    - Counter advances only on WAITREQUEST=0. After the last word: cursor (0,0), clear_pend=0, IDLE.
//  - BUSY = (state!=IDLE) | clear_pend. CURSOR_* are registered and change only at completion/accept.
// TESTING
//  1. Reset; 'A' code 0x41, attr 0x1F -> one write ADDR 0, BE 0011, DATA 0x0000411F; cursor (1,0).
//  2. Then 0xC2 attr 0x20 -> ADDR 0, BE 1100, DATA 0xC2200000; cursor (2,0); 2 cycles/char, no stall.
//  3. Cursor (79,29), send 0x5A -> ADDR 1199, BE 1100; cursor wraps to (0,0).
//  4. WAITREQUEST high 3 cycles -> AVM_* stable 4 cycles, CHAR_READY=0; cursor moves after completion only.
//  5. CLEAR_REQ attr 0x07 -> exactly 1200 writes, ADDR 0..1199, DATA 0x20072007, BE 1111; cursor (0,0).
//     BUSY falls the cycle after the last write. RESET_N low mid-clear -> AVM_WRITE=0 immediately.
//  6. At (5,3): LF -> (0,4), no write; BS at col 0 -> unchanged.
//     CLEAR_REQ with CHAR_VALID in the same cycle -> clear runs first, char written at (0,0) after.

Source files
------------

// File: rtl/vga_text_console_master.sv
// Avalon-MM master that prints a valid/ready character stream into the VGA text VRAM
// (two characters per 32-bit word), tracking an 80x30 cursor and supporting full-screen clear.
module vga_text_console_master #(
    parameter int COLS      = 80,
    parameter int ROWS      = 30,
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              CHAR_VALID,
    output logic              CHAR_READY,
    input  logic [7:0]        CHAR_CODE,
    input  logic [7:0]        CHAR_ATTR,
    input  logic              CLEAR_REQ,
    input  logic [7:0]        CLEAR_ATTR,
    output logic              BUSY,
    output logic [6:0]        CURSOR_COL,
    output logic [4:0]        CURSOR_ROW,
    output logic [ADDR_W-1:0] AVM_ADDR,
    output logic              AVM_WRITE,
    output logic [3:0]        AVM_BYTE_EN,
    output logic [31:0]       AVM_WRITEDATA,
    input  logic              AVM_WAITREQUEST
);

    localparam int CLR_WORDS = COLS * ROWS / 2;
    localparam int CNT_W     = $clog2(CLR_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [6:0]          col_q, col_d;
    logic [4:0]          row_q, row_d;
    logic                clear_pend_q, clear_pend_d;
    logic [7:0]          clr_attr_q, clr_attr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [3:0]          be_q, be_d;
    logic [31:0]         data_q, data_d;

    logic                ready_s;
    logic                accept_s;
    logic [7:0]          clr_attr_sel_s;
    logic [11:0]         idx_s;
    logic [4:0]          row_inc_s;
    logic [CNT_W-1:0]    cnt_inc_s;

    // Next-state, cursor and Avalon request computation.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        clear_pend_d = clear_pend_q;
        clr_attr_d   = clr_attr_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        write_d      = write_q;
        be_d         = be_q;
        data_d       = data_q;

        ready_s        = RESET_N & (state_q == ST_IDLE) & ~clear_pend_q & ~CLEAR_REQ;
        accept_s       = CHAR_VALID & ready_s;
        clr_attr_sel_s = CLEAR_REQ ? CLEAR_ATTR : clr_attr_q;
        idx_s          = 12'(row_q) * 12'(COLS) + 12'(col_q);
        row_inc_s      = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;
        cnt_inc_s      = cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                // A fresh or pending clear always wins over the character stream.
                if (CLEAR_REQ || clear_pend_q) begin
                    state_d    = ST_CLEAR;
                    clr_attr_d = clr_attr_sel_s;
                    cnt_d      = '0;
                    write_d    = 1'b1;
                    addr_d     = ADDR_W'(BASE_ADDR);
                    be_d       = 4'b1111;
                    data_d     = {8'h20, clr_attr_sel_s, 8'h20, clr_attr_sel_s};
                end else if (accept_s) begin
                    case (CHAR_CODE)
                        8'h0A: begin
                            col_d = 7'd0;
                            row_d = row_inc_s;
                        end
                        8'h0D: begin
                            col_d = 7'd0;
                        end
                        8'h08: begin
                            if (col_q != 7'd0) begin
                                col_d = col_q - 7'd1;
                            end else begin
                                col_d = col_q;
                            end
                        end
                        default: begin
                            state_d = ST_WRITE;
                            write_d = 1'b1;
                            addr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_s[11:1]);
                            if (col_q[0]) begin
                                be_d   = 4'b1100;
                                data_d = {CHAR_CODE, CHAR_ATTR, 16'h0000};
                            end else begin
                                be_d   = 4'b0011;
                                data_d = {16'h0000, CHAR_CODE, CHAR_ATTR};
                            end
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WRITE: begin
                if (CLEAR_REQ) begin
                    clear_pend_d = 1'b1;
                    clr_attr_d   = CLEAR_ATTR;
                end else begin
                    clear_pend_d = clear_pend_q;
                end
                if (!AVM_WAITREQUEST) begin
                    state_d = ST_IDLE;
                    write_d = 1'b0;
                    if (col_q == 7'(COLS - 1)) begin
                        col_d = 7'd0;
                        row_d = row_inc_s;
                    end else begin
                        col_d = col_q + 7'd1;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end

            ST_CLEAR: begin
                // Data word is constant for the whole clear; only the address walks.
                if (!AVM_WAITREQUEST) begin
                    if (cnt_q == CNT_W'(CLR_WORDS - 1)) begin
                        state_d      = ST_IDLE;
                        write_d      = 1'b0;
                        col_d        = 7'd0;
                        row_d        = 5'd0;
                        clear_pend_d = 1'b0;
                    end else begin
                        cnt_d  = cnt_inc_s;
                        addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(cnt_inc_s);
                    end
                end else begin
                    state_d = ST_CLEAR;
                end
            end

            default: begin
                state_d = ST_IDLE;
                write_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            col_q        <= 7'd0;
            row_q        <= 5'd0;
            clear_pend_q <= 1'b0;
            clr_attr_q   <= 8'h00;
            cnt_q        <= '0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            be_q         <= 4'b0000;
            data_q       <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            clear_pend_q <= clear_pend_d;
            clr_attr_q   <= clr_attr_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            be_q         <= be_d;
            data_q       <= data_d;
        end
    end

    assign CHAR_READY    = ready_s;
    assign BUSY          = (state_q != ST_IDLE) | clear_pend_q;
    assign CURSOR_COL    = col_q;
    assign CURSOR_ROW    = row_q;
    assign AVM_ADDR      = addr_q;
    assign AVM_WRITE     = write_q;
    assign AVM_BYTE_EN   = be_q;
    assign AVM_WRITEDATA = data_q;

endmodule

// File: tb/tb_vga_text_console_master.sv
// Scoreboard bench for vga_text_console_master: expected VRAM writes are queued as
// characters/clears are issued and compared as the master completes each write.
module tb_vga_text_console_master;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        CHAR_VALID = 1'b0;
    logic        CHAR_READY;
    logic [7:0]  CHAR_CODE = 8'h00;
    logic [7:0]  CHAR_ATTR = 8'h00;
    logic        CLEAR_REQ = 1'b0;
    logic [7:0]  CLEAR_ATTR = 8'h00;
    logic        BUSY;
    logic [6:0]  CURSOR_COL;
    logic [4:0]  CURSOR_ROW;
    logic [11:0] AVM_ADDR;
    logic        AVM_WRITE;
    logic [3:0]  AVM_BYTE_EN;
    logic [31:0] AVM_WRITEDATA;
    logic        AVM_WAITREQUEST = 1'b0;

    int n_cmp = 0;
    int n_mis = 0;
    int wr_count = 0;
    int m_col = 0;
    int m_row = 0;
    logic [47:0] exp_q[$];

    vga_text_console_master #(.COLS(80), .ROWS(30), .ADDR_W(12), .BASE_ADDR(0)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .CHAR_VALID(CHAR_VALID), .CHAR_READY(CHAR_READY),
        .CHAR_CODE(CHAR_CODE), .CHAR_ATTR(CHAR_ATTR),
        .CLEAR_REQ(CLEAR_REQ), .CLEAR_ATTR(CLEAR_ATTR),
        .BUSY(BUSY), .CURSOR_COL(CURSOR_COL), .CURSOR_ROW(CURSOR_ROW),
        .AVM_ADDR(AVM_ADDR), .AVM_WRITE(AVM_WRITE), .AVM_BYTE_EN(AVM_BYTE_EN),
        .AVM_WRITEDATA(AVM_WRITEDATA), .AVM_WAITREQUEST(AVM_WAITREQUEST)
    );

    always #10 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Completed writes are those with WAITREQUEST low; sampled on the falling edge.
    always @(negedge CLK) begin
        if (RESET_N && AVM_WRITE && !AVM_WAITREQUEST) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                check_val("unexp_wr", 64'(exp_q.size()), 64'd1);
            end else begin
                check_val("vram_wr", {AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA}, exp_q.pop_front());
            end
        end
    end

    task automatic model_char(input logic [7:0] c, input logic [7:0] a);
        int idx;
        if (c == 8'h0A) begin
            m_col = 0;
            m_row = (m_row == 29) ? 0 : m_row + 1;
        end else if (c == 8'h0D) begin
            m_col = 0;
        end else if (c == 8'h08) begin
            if (m_col > 0) m_col = m_col - 1;
        end else begin
            idx = m_row * 80 + m_col;
            if (m_col % 2 == 1)
                exp_q.push_back({12'(idx / 2), 4'b1100, c, a, 16'h0000});
            else
                exp_q.push_back({12'(idx / 2), 4'b0011, 16'h0000, c, a});
            if (m_col == 79) begin
                m_col = 0;
                m_row = (m_row == 29) ? 0 : m_row + 1;
            end else begin
                m_col = m_col + 1;
            end
        end
    endtask

    task automatic model_clear(input logic [7:0] a);
        for (int i = 0; i < 1200; i++)
            exp_q.push_back({12'(i), 4'b1111, 8'h20, a, 8'h20, a});
        m_col = 0;
        m_row = 0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 5000 && !CHAR_READY; i++) tick();
        if (!CHAR_READY) check_val("ready_timeout", 64'(CHAR_READY), 64'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 5000 && BUSY; i++) tick();
        if (BUSY) check_val("idle_timeout", 64'(BUSY), 64'd0);
    endtask

    // Drives one character; returns 1 ns after the accepting edge.
    task automatic send_char(input logic [7:0] c, input logic [7:0] a);
        model_char(c, a);
        CHAR_CODE  = c;
        CHAR_ATTR  = a;
        CHAR_VALID = 1'b1;
        wait_ready();
        tick();
        CHAR_VALID = 1'b0;
    endtask

    task automatic check_cursor(input string tag);
        check_val({tag, "_col"}, 64'(CURSOR_COL), 64'(m_col));
        check_val({tag, "_row"}, 64'(CURSOR_ROW), 64'(m_row));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [47:0] held;
        int wc;
        logic last_seen;

        // 1: reset state and first character
        #35;
        check_val("rst_ready", 64'(CHAR_READY), 64'd0);
        check_val("rst_write", 64'(AVM_WRITE), 64'd0);
        check_val("rst_avm", {AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA}, 64'd0);
        check_val("rst_busy", 64'(BUSY), 64'd0);
        check_val("rst_cursor", {CURSOR_COL, CURSOR_ROW}, 64'd0);
        RESET_N = 1'b1;
        tick();
        check_val("post_rst_ready", 64'(CHAR_READY), 64'd1);
        send_char(8'h41, 8'h1F);
        wait_idle();
        check_val("a_cursor_col", 64'(CURSOR_COL), 64'd1);
        check_cursor("a");

        // 2: odd column, two cycles per char
        send_char(8'hC2, 8'h20);
        check_val("lat_write_n1", 64'(AVM_WRITE), 64'd1);
        check_val("lat_ready_n1", 64'(CHAR_READY), 64'd0);
        check_val("odd_data", 64'(AVM_WRITEDATA), 64'hC220_0000);
        tick();
        check_val("lat_write_n2", 64'(AVM_WRITE), 64'd0);
        check_val("lat_ready_n2", 64'(CHAR_READY), 64'd1);
        check_val("c2_cursor_col", 64'(CURSOR_COL), 64'd2);

        // 3: last cell and wrap to (0,0)
        send_char(8'h0D, 8'h00);
        for (int i = 0; i < 29; i++) send_char(8'h0A, 8'h00);
        for (int i = 0; i < 79; i++) begin
            send_char(8'h30 + 8'(i % 10), 8'(i));
            wait_idle();
        end
        check_cursor("pre_wrap");
        send_char(8'h5A, 8'h4E);
        check_val("wrap_addr", 64'(AVM_ADDR), 64'd1199);
        check_val("wrap_be", 64'(AVM_BYTE_EN), 64'b1100);
        wait_idle();
        check_val("wrap_cursor", {CURSOR_COL, CURSOR_ROW}, 64'd0);

        // 4: three stall cycles, plus a clear requested mid-write
        AVM_WAITREQUEST = 1'b1;
        send_char(8'h62, 8'h71);
        held = {AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA};
        check_val("stall_first", held, {12'd0, 4'b0011, 16'h0000, 8'h62, 8'h71});
        for (int i = 0; i < 3; i++) begin
            check_val("stall_write", 64'(AVM_WRITE), 64'd1);
            check_val("stall_hold", {AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA}, held);
            check_val("stall_ready", 64'(CHAR_READY), 64'd0);
            check_val("stall_cursor", 64'(CURSOR_COL), 64'd0);
            if (i == 0) begin
                CLEAR_REQ  = 1'b1;
                CLEAR_ATTR = 8'h3C;
                model_clear(8'h3C);
            end
            tick();
            CLEAR_REQ  = 1'b0;
            CLEAR_ATTR = 8'hA5;
        end
        AVM_WAITREQUEST = 1'b0;
        check_val("stall_hold4", {AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA}, held);
        check_val("stall_cursor4", 64'(CURSOR_COL), 64'd0);
        tick();
        check_val("stall_done_col", 64'(CURSOR_COL), 64'd1);
        check_val("pend_busy", 64'(BUSY), 64'd1);
        wait_idle();
        check_cursor("pend_clear");

        // 5: clear with random stalls, then reset mid-clear
        send_char(8'h58, 8'h11);
        wait_idle();
        model_clear(8'h07);
        wc = wr_count;
        CLEAR_REQ  = 1'b1;
        CLEAR_ATTR = 8'h07;
        tick();
        CLEAR_REQ  = 1'b0;
        CLEAR_ATTR = 8'hFF;
        check_val("clr_busy", 64'(BUSY), 64'd1);
        last_seen = 1'b0;
        for (int i = 0; i < 6000 && !last_seen; i++) begin
            AVM_WAITREQUEST = ($urandom_range(0, 3) == 0);
            if (AVM_WRITE && !AVM_WAITREQUEST && AVM_ADDR == 12'd1199) last_seen = 1'b1;
            else tick();
        end
        check_val("clr_last_seen", 64'(last_seen), 64'd1);
        tick();
        AVM_WAITREQUEST = 1'b0;
        check_val("clr_busy_fall", 64'(BUSY), 64'd0);
        check_val("clr_write_fall", 64'(AVM_WRITE), 64'd0);
        check_val("clr_count", 64'(wr_count - wc), 64'd1200);
        check_val("clr_cursor", {CURSOR_COL, CURSOR_ROW}, 64'd0);

        model_clear(8'h55);
        CLEAR_REQ  = 1'b1;
        CLEAR_ATTR = 8'h55;
        tick();
        CLEAR_REQ = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        RESET_N = 1'b0;
        #1;
        check_val("rst_abort_write", 64'(AVM_WRITE), 64'd0);
        check_val("rst_abort_busy", 64'(BUSY), 64'd0);
        check_val("rst_abort_ready", 64'(CHAR_READY), 64'd0);
        exp_q.delete();
        m_col = 0;
        m_row = 0;
        #3;
        RESET_N = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check_val("no_resume", 64'(AVM_WRITE), 64'd0);

        // 6: control codes and clear-vs-char priority
        for (int i = 0; i < 3; i++) send_char(8'h0A, 8'h00);
        for (int i = 0; i < 5; i++) begin
            send_char(8'h61 + 8'(i), 8'h2B);
            wait_idle();
        end
        check_val("at_5_3", {CURSOR_COL, CURSOR_ROW}, {7'd5, 5'd3});
        wc = wr_count;
        send_char(8'h0A, 8'h00);
        tick();
        tick();
        check_val("lf_cursor", {CURSOR_COL, CURSOR_ROW}, {7'd0, 5'd4});
        check_val("lf_no_write", 64'(wr_count), 64'(wc));
        send_char(8'h08, 8'h00);
        tick();
        check_val("bs_col0", {CURSOR_COL, CURSOR_ROW}, {7'd0, 5'd4});
        send_char(8'h71, 8'h2B);
        wait_idle();
        send_char(8'h08, 8'h00);
        tick();
        check_val("bs_col1", {CURSOR_COL, CURSOR_ROW}, {7'd0, 5'd4});
        send_char(8'h72, 8'h2B);
        wait_idle();
        send_char(8'h73, 8'h2B);
        wait_idle();
        send_char(8'h0D, 8'h00);
        tick();
        check_val("cr_cursor", {CURSOR_COL, CURSOR_ROW}, {7'd0, 5'd4});

        model_clear(8'h12);
        model_char(8'h5A, 8'h34);
        CHAR_CODE  = 8'h5A;
        CHAR_ATTR  = 8'h34;
        CHAR_VALID = 1'b1;
        CLEAR_REQ  = 1'b1;
        CLEAR_ATTR = 8'h12;
        #1;
        check_val("clr_blocks_ready", 64'(CHAR_READY), 64'd0);
        tick();
        CLEAR_REQ = 1'b0;
        check_val("clr_first_be", 64'(AVM_BYTE_EN), 64'b1111);
        wait_ready();
        tick();
        CHAR_VALID = 1'b0;
        wait_idle();
        check_val("after_clr_char", {CURSOR_COL, CURSOR_ROW}, {7'd1, 5'd0});

        tick();
        check_val("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
